iob_fifo_async_wr_arbiter: RTL
==============================

Name: iob_fifo_async_wr_arbiter

Overview:
- Shares the single write port of an iob_fifo_async instance among N requesters, with burst (packet) granularity.
- A requester announces a burst length. The arbiter grants the burst only when the FIFO has room for the whole burst, then streams its beats into the FIFO write port.
- The block sits entirely in the FIFO write clock domain, between the producers and the iob_fifo_async write port.

Parameters:
- N, 4: number of requesters (N >= 2).
- DATA_W, 8: FIFO write data width (equals the FIFO's W_DATA_W).
- ADDR_W, 4: FIFO write-side address width. FIFO depth is DEPTH = 2**ADDR_W words.
- LEN_W, ADDR_W+1: width of each burst length field.

Ports:
- w_clk_i  in  1  clock w_clk (FIFO write clock).
- arst_i  in  1  reset arst, asynchronous, active-high.
- cke_i  in  1  clock enable; 0 freezes all state.
- req_i  in  N  burst request, one bit per requester, level-held until granted.
- len_i  in  N*LEN_W  burst length per requester; field k is bits [k*LEN_W +: LEN_W].
- valid_i  in  N  beat valid per requester.
- data_i  in  N*DATA_W  beat data per requester.
- ready_o  out  N  beat accepted (beat handshake).
- grant_o  out  N  one-hot grant, held for the whole burst.
- done_o  out  N  one-cycle pulse after the last beat of a burst.
- busy_o  out  1  a burst is in progress.
- fifo_w_en_o  out  1  FIFO write enable.
- fifo_w_data_o  out  DATA_W  FIFO write data.
- fifo_w_full_i  in  1  FIFO w_full.
- fifo_w_level_i  in  ADDR_W+1  FIFO w_level; includes writes made on the previous edge.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=0, cnt=0, gsel=0.
  - grant_o, ready_o, done_o, busy_o and fifo_w_en_o are all 0.
  - fifo_w_data_o=0.
- Reset asserted mid-burst aborts the burst; the partial data already written stays in the FIFO.
- Free space: free = DEPTH - fifo_w_level_i, computed LEN_W+1 bits wide with no wrap.
- Eligibility: requester k is eligible iff req_i[k]=1, 1 <= len_k <= DEPTH, and len_k <= free.
  - len_k=0 or len_k>DEPTH is never granted, so the request stays pending forever.
- State IDLE:
  - Search eligible requesters in rotated order rr_ptr, rr_ptr+1, ..., wrapping modulo N. The first eligible one wins.
  - An ineligible higher-priority requester (insufficient space) is skipped, not waited on.
  - On a winner g: gsel<=g, cnt<=len_g, state<=BURST.
  - If there is no winner, stay in IDLE.
- State BURST:
  - grant_o = one-hot(gsel); busy_o=1.
  - ready_o[gsel] = !fifo_w_full_i; all other ready bits are 0.
  - fifo_w_en_o = valid_i[gsel] & ready_o[gsel]; fifo_w_data_o = data_i of gsel. Both are combinational.
  - Each beat decrements cnt.
  - On the beat with cnt==1: state<=IDLE, rr_ptr<=(gsel+1) mod N, done_o[gsel]<=1 for the next cycle only.
  - Gaps are allowed: valid_i=0 writes nothing and keeps the grant.
  - Changes to req_i or len_i during BURST are ignored.
- Outputs in IDLE and while cke_i=0: fifo_w_en_o=0 and ready_o=0.
  - In IDLE, fifo_w_data_o holds the last value.
  - While cke_i=0, state, counters and done_o hold.
- Latency:
  - A request seen eligible in IDLE at edge t gets grant_o high from t, and its first beat can be accepted at edge t+1.
  - Back-to-back bursts are separated by exactly one IDLE cycle, which lets fifo_w_level_i include the last beat.
- Full: space is reserved, so fifo_w_full_i=1 during a burst is only a safety case. ready_o drops and nothing is written or lost.
- Fairness: a long burst may starve while shorter bursts keep fitting. This is accepted.

Test Plan:
- Single request: req0, len=4, FIFO empty → grant_o=0001 the cycle after req, 4 consecutive fifo_w_en_o beats carry data0, done_o[0] pulses once, busy_o returns to 0.
- Round robin: all 4 requesting len=2 continuously, reader draining → grant order 0,1,2,3,0, one IDLE cycle between bursts.
- Space check: w_level=14 (free 2), req0 len=4 and req1 len=2, rr_ptr=0 → requester 1 granted first; requester 0 granted once free>=4.
- Invalid lengths: len=0 and len=17 (ADDR_W=4) → never granted, others still served.
- Stall: valid gaps and forced fifo_w_full_i=1 mid-burst → no write while full, beat count still exactly len, data order preserved.
- Reset mid-burst after 2 of 5 beats → all outputs 0 immediately; first grant after release goes to requester 0.

Source files
------------

// File: rtl/iob_fifo_async_wr_arbiter.sv
// Burst-granular round-robin arbiter that shares one iob_fifo_async write port among N producers.
// A burst is granted only when the FIFO has room for all of its beats.
module iob_fifo_async_wr_arbiter #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic                w_clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic [N-1:0]        req_i,
    input  logic [N*LEN_W-1:0]  len_i,
    input  logic [N-1:0]        valid_i,
    input  logic [N*DATA_W-1:0] data_i,
    output logic [N-1:0]        ready_o,
    output logic [N-1:0]        grant_o,
    output logic [N-1:0]        done_o,
    output logic                busy_o,
    output logic                fifo_w_en_o,
    output logic [DATA_W-1:0]   fifo_w_data_o,
    input  logic                fifo_w_full_i,
    input  logic [ADDR_W:0]     fifo_w_level_i
);
    localparam int unsigned    PTR_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [LEN_W:0] DEPTH    = (LEN_W + 1)'(2 ** ADDR_W);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

    typedef enum logic {StIdle, StBurst} state_t;

    state_t            r_state, w_state_d;
    logic [PTR_W-1:0]  r_rr_ptr, w_rr_ptr_d;
    logic [PTR_W-1:0]  r_gsel, w_gsel_d;
    logic [LEN_W-1:0]  r_cnt, w_cnt_d;
    logic [N-1:0]      r_done, w_done_d;
    logic [DATA_W-1:0] r_wdata, w_wdata_d;

    logic [LEN_W:0]    w_level_ext;
    logic [LEN_W:0]    w_free;
    logic [N-1:0]      w_elig;
    logic [31:0]       w_k;
    logic              w_win_found;
    logic [PTR_W-1:0]  w_win_idx;
    logic [LEN_W-1:0]  w_win_len;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_valid;
    logic [N-1:0]      w_gsel_oh;
    logic              w_busy;
    logic              w_ready;
    logic              w_beat;

    // Free space saturates at zero rather than wrapping on an out-of-range level.
    assign w_level_ext = (LEN_W + 1)'(fifo_w_level_i);
    assign w_free      = (w_level_ext >= DEPTH) ? '0 : DEPTH - w_level_ext;

    for (genvar g = 0; g < N; g++) begin : g_elig
        logic [LEN_W:0] w_len_ext;
        assign w_len_ext = {1'b0, len_i[g*LEN_W +: LEN_W]};
        assign w_elig[g] = req_i[g] && (w_len_ext != '0) && (w_len_ext <= DEPTH)
                           && (w_len_ext <= w_free);
    end

    // First eligible requester starting at rr_ptr wins; ineligible ones are skipped.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_k         = '0;
        for (int i = 0; i < N; i++) begin
            w_k = 32'(r_rr_ptr) + 32'(i);
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            if (!w_win_found && w_elig[w_k[PTR_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_k[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        w_win_len  = '0;
        for (int k = 0; k < N; k++) begin
            if (r_gsel == PTR_W'(k)) begin
                w_sel_data = data_i[k*DATA_W +: DATA_W];
            end
            if (w_win_idx == PTR_W'(k)) begin
                w_win_len = len_i[k*LEN_W +: LEN_W];
            end
        end
    end

    assign w_sel_valid = valid_i[r_gsel];
    assign w_gsel_oh   = N'(1) << r_gsel;
    assign w_busy      = (r_state == StBurst);
    assign w_ready     = w_busy && cke_i && !fifo_w_full_i;
    assign w_beat      = w_ready && w_sel_valid;

    assign busy_o        = w_busy;
    assign grant_o       = w_busy ? w_gsel_oh : '0;
    assign ready_o       = w_ready ? w_gsel_oh : '0;
    assign done_o        = r_done;
    assign fifo_w_en_o   = w_beat;
    assign fifo_w_data_o = w_busy ? w_sel_data : r_wdata;

    always_comb begin
        w_state_d  = r_state;
        w_rr_ptr_d = r_rr_ptr;
        w_gsel_d   = r_gsel;
        w_cnt_d    = r_cnt;
        w_done_d   = '0;
        w_wdata_d  = r_wdata;
        unique case (r_state)
            StIdle: begin
                if (w_win_found) begin
                    w_gsel_d  = w_win_idx;
                    w_cnt_d   = w_win_len;
                    w_state_d = StBurst;
                end
            end
            StBurst: begin
                if (w_beat) begin
                    w_wdata_d = w_sel_data;
                    w_cnt_d   = r_cnt - 1'b1;
                    if (r_cnt == LEN_W'(1)) begin
                        w_state_d  = StIdle;
                        w_rr_ptr_d = (r_gsel == LAST_IDX) ? '0 : r_gsel + 1'b1;
                        w_done_d   = w_gsel_oh;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge w_clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state  <= StIdle;
            r_rr_ptr <= '0;
            r_gsel   <= '0;
            r_cnt    <= '0;
            r_done   <= '0;
            r_wdata  <= '0;
        end else if (cke_i) begin
            r_state  <= w_state_d;
            r_rr_ptr <= w_rr_ptr_d;
            r_gsel   <= w_gsel_d;
            r_cnt    <= w_cnt_d;
            r_done   <= w_done_d;
            r_wdata  <= w_wdata_d;
        end
    end

endmodule
